// File: rtl/pc_flow_ctrl.sv
// -----------------------------------------------------------------------------
// pc_flow_ctrl
//
// Fetch-flow controller for a classic five-stage front end. It combines three
// sources of fetch disruption: taken-branch redirects from EX, load-use
// hazards from ID, and instruction-memory wait states. From these it drives
// the PC register controls and the squash/hold strobes of the IF/ID and ID/EX
// pipeline latches.
//
// Priority in every state: br_taken > ld_use > !imem_rdy.
//
// All control outputs are Mealy: they depend on the registered state and the
// current inputs, so a cause and its response appear in the same cycle. Only
// the FSM state, the 3-bit down-counter and the optional performance counters
// are registered.
//
// Optional feature (compile-time macro PERF_CNT_EN):
//   When defined, the ports stall_cnt and flush_cnt exist. They are saturating
//   counters, cleared only by rst. When undefined, both ports and their
//   registers are absent.
//
// Parameters
//   DBITS        datapath / PC width
//   FLUSH_CYCLES extra IF-bubble cycles after a redirect (0..7)
//   LU_CYCLES    PC/ID hold cycles per load-use hazard (1..7)
//   CNT_BITS     performance counter width
//
// Ports
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous, active-high reset
//   br_taken   in   1         EX resolved a taken branch/jump (1-cycle pulse)
//   br_target  in   DBITS     redirect address, valid with br_taken
//   ld_use     in   1         ID detected a load-use hazard
//   imem_rdy   in   1         instruction memory returns valid data this cycle
//   pc_jmp     out  1         load pc_target into PC at the next edge
//   pc_stall   out  1         hold PC
//   pc_target  out  DBITS     word-aligned br_target
//   flush_if   out  1         write NOOP into the IF/ID latch
//   flush_id   out  1         write NOOP into the ID/EX latch
//   id_hold    out  1         hold the IF/ID latch contents
//   busy       out  1         controller is not in normal RUN flow
//   stall_cnt  out  CNT_BITS  cycles with pc_stall=1      (PERF_CNT_EN only)
//   flush_cnt  out  CNT_BITS  accepted redirects          (PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pc_flow_ctrl #(
  parameter int DBITS        = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int LU_CYCLES    = 1,
  parameter int CNT_BITS     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_taken,
  input  logic [DBITS-1:0] br_target,
  input  logic             ld_use,
  input  logic             imem_rdy,
  output logic             pc_jmp,
  output logic             pc_stall,
  output logic [DBITS-1:0] pc_target,
  output logic             flush_if,
  output logic             flush_id,
  output logic             id_hold,
  output logic             busy
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [2:0] LU_LOAD    = 3'(LU_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;

  // Low address bits are dropped by word alignment of the redirect target.
  logic unused_target_bits;
  assign unused_target_bits = ^br_target[1:0];

  assign pc_target = {br_target[DBITS-1:2], 2'b00};

  // MEM_WAIT decodes exactly like RUN: the cycle in which imem_rdy returns is
  // a normal RUN cycle, and ld_use keeps its priority over a missing fetch.
  logic run_like;
  assign run_like = (state == RUN) || (state == MEM_WAIT);

  // ---------------------------------------------------------------------------
  // Mealy output decode
  // ---------------------------------------------------------------------------
  logic jmp_d, stall_d, flush_if_d, flush_id_d, hold_d, busy_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    jmp_d      = 1'b0;
    stall_d    = 1'b0;
    flush_if_d = 1'b0;
    flush_id_d = 1'b0;
    hold_d     = 1'b0;
    busy_d     = (state != RUN) && !((state == MEM_WAIT) && imem_rdy);

    if (br_taken) begin
      // Redirect wins over any hold or wait: squash both front-end latches.
      jmp_d      = 1'b1;
      flush_if_d = 1'b1;
      flush_id_d = 1'b1;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (ld_use) begin
            stall_d    = 1'b1;
            hold_d     = 1'b1;
            flush_id_d = 1'b1;
          end else if (!imem_rdy) begin
            stall_d    = 1'b1;
            flush_if_d = 1'b1;
          end
        end
        LU_HOLD: begin
          stall_d    = 1'b1;
          hold_d     = 1'b1;
          flush_id_d = 1'b1;
        end
        FLUSH: begin
          // ID already holds a bubble, so ld_use is irrelevant here.
          flush_if_d = 1'b1;
          stall_d    = !imem_rdy;
        end
        default: ;
      endcase
    end
  end

  // Reset forces every control strobe low; the target is pure wiring.
  always_comb begin
    pc_jmp   = jmp_d      && !rst;
    pc_stall = stall_d    && !rst;
    flush_if = flush_if_d && !rst;
    flush_id = flush_id_d && !rst;
    id_hold  = hold_d     && !rst;
    busy     = busy_d     && !rst;
  end

  // ---------------------------------------------------------------------------
  // State and down-counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else if (br_taken) begin
      if (FLUSH_CYCLES == 0) begin
        state <= RUN;
        cnt   <= 3'd0;
      end else begin
        state <= FLUSH;
        cnt   <= FLUSH_LOAD;
      end
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (ld_use) begin
            if (LU_CYCLES <= 1) begin
              state <= RUN;
              cnt   <= 3'd0;
            end else begin
              state <= LU_HOLD;
              cnt   <= LU_LOAD;
            end
          end else if (!imem_rdy) begin
            state <= MEM_WAIT;
          end else begin
            state <= RUN;
          end
        end
        LU_HOLD: begin
          // A count of 0 cannot be loaded; treat it like 1 so the FSM
          // can never get stuck.
          if (cnt <= 3'd1) begin
            state <= RUN;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        FLUSH: begin
          // The refill only advances on cycles that deliver an instruction.
          if (imem_rdy) begin
            if (cnt <= 3'd1) begin
              state <= RUN;
              cnt   <= 3'd0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_BITS'(1);
      end
      if (br_taken && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_BITS'(1);
      end
    end
  end
`else
  localparam int unused_cnt_bits = CNT_BITS;
`endif

endmodule
